// File: rtl/io_dma_master.sv
// Single-channel word-copy DMA initiator on the peripheral I/O bus; all outputs registered.
// Optional feature macro DMA_TIMEOUT_EN: bounded WAIT states, status=1 on expiry.
module io_dma_master #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16,
  parameter int MAX_BIT_POS    = 31
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [MAX_BIT_POS:0] src_addr,
  input  logic [MAX_BIT_POS:0] dst_addr,
  input  logic [CNT_W-1:0]     word_count,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           status,
  output logic [MAX_BIT_POS:0] io_addr,
  output logic                 io_read,
  output logic                 io_write,
  output logic                 burst,
  output logic [2:0]           burst_size,
  output logic                 read_ready,
  output logic [MAX_BIT_POS:0] io_wdata,
  output logic [1:0]           io_byte_size,
  input  logic [MAX_BIT_POS:0] io_rdata,
  input  logic                 io_ready
);

  localparam int AW = MAX_BIT_POS + 1;

  typedef enum logic [2:0] {
    IDLE, RD_SETUP, RD_WAIT, RD_ACK, WR_SETUP, WR_WAIT, FIN
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    src_q, src_d, dst_q, dst_d, data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       status_d;
  logic             in_busy, in_wait, tmo_hit, busy_d;

  assign in_busy = (state_q != IDLE) && (state_q != FIN);
  assign in_wait = (state_q == RD_WAIT) || (state_q == WR_WAIT);
  assign busy_d  = (state_d != IDLE) && (state_d != FIN);

`ifdef DMA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Any state change (including re-entry of a WAIT state) restarts the count.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)                   tmo_cnt <= '0;
    else if (state_q != state_d)  tmo_cnt <= '0;
    else if (in_wait && !io_ready) tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = in_wait && !io_ready && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    status_d = status;
    case (state_q)
      IDLE: if (start && !abort) begin
        src_d    = src_addr;
        dst_d    = dst_addr;
        cnt_d    = word_count;
        status_d = 2'd0;
        state_d  = (word_count == '0) ? FIN : RD_SETUP;
      end
      RD_SETUP: state_d = RD_WAIT;
      RD_WAIT: if (io_ready) begin
        data_d  = io_rdata;
        state_d = RD_ACK;
      end
      RD_ACK: begin
        src_d   = src_q + AW'(4);
        state_d = WR_SETUP;
      end
      WR_SETUP: state_d = WR_WAIT;
      WR_WAIT: if (io_ready) begin
        dst_d   = dst_q + AW'(4);
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == CNT_W'(1)) ? FIN : RD_SETUP;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort beats a simultaneous io_ready: the beat is discarded, not counted.
    if (in_busy && abort) begin
      state_d  = FIN;
      status_d = 2'd2;
      src_d    = src_q;
      dst_d    = dst_q;
      data_d   = data_q;
      cnt_d    = cnt_q;
    end else if (tmo_hit) begin
      state_d  = FIN;
      status_d = 2'd1;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      status       <= 2'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      io_read      <= 1'b0;
      io_write     <= 1'b0;
      read_ready   <= 1'b0;
      io_byte_size <= 2'b00;
      io_addr      <= '0;
      io_wdata     <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      status       <= status_d;
      // Outputs decode the next state so they are registered yet track state_q.
      busy         <= busy_d;
      done         <= (state_d == FIN);
      io_read      <= (state_d == RD_WAIT);
      io_write     <= (state_d == WR_WAIT);
      read_ready   <= (state_d == RD_ACK);
      io_byte_size <= busy_d ? 2'b10 : 2'b00;
      if (state_d == RD_SETUP || state_d == RD_WAIT)
        io_addr <= src_d;
      else if (state_d == WR_SETUP || state_d == WR_WAIT) begin
        io_addr  <= dst_d;
        io_wdata <= data_d;
      end
    end
  end

  assign burst      = 1'b0;
  assign burst_size = 3'd0;

endmodule

// File: tb/tb_io_dma_master.sv
// Directed bench for io_dma_master with a negedge-driven bus model of programmable io_ready delay.
module tb_io_dma_master;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0;
  logic [15:0] word_count = '0;
  logic        busy, done, io_read, io_write, burst, read_ready;
  logic [1:0]  status, io_byte_size;
  logic [2:0]  burst_size;
  logic [31:0] io_addr, io_wdata;
  logic [31:0] io_rdata = '0;
  logic        io_ready = 1'b0;

  io_dma_master #(.TIMEOUT_CYCLES(8), .CNT_W(16), .MAX_BIT_POS(31)) dut (
    .pclk(pclk), .rst_n(rst_n), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
    .busy(busy), .done(done), .status(status), .io_addr(io_addr),
    .io_read(io_read), .io_write(io_write), .burst(burst), .burst_size(burst_size),
    .read_ready(read_ready), .io_wdata(io_wdata), .io_byte_size(io_byte_size),
    .io_rdata(io_rdata), .io_ready(io_ready)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0, n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Bus model and monitors, all evaluated on the falling edge.
  int          tick = 0, bcnt = 0, dly = 0;
  logic [31:0] rd_vals [4];
  int          rd_idx = 0;
  logic [31:0] wr_addr [8];
  logic [31:0] wr_dat  [8];
  int          wr_n = 0, done_cnt = 0, done_tick = 0, first_rd = -1;
  int          rr_cnt = 0, rr_multi = 0, stab_err = 0, both_hi = 0, bsz_err = 0, rd_hi = 0;
  logic        busy_seen = 0, strobe_seen = 0, prev_rr = 0, prev_rd = 0, prev_wr = 0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;

  always @(negedge pclk) begin
    tick++;
    if (io_read || io_write) begin
      if (!io_ready && bcnt == dly) begin
        io_ready = 1'b1;
        if (io_read) begin
          io_rdata = rd_vals[rd_idx % 4];
          rd_idx++;
        end else if (wr_n < 8) begin
          wr_addr[wr_n] = io_addr;
          wr_dat[wr_n]  = io_wdata;
          wr_n++;
        end
      end else
        io_ready = 1'b0;
      bcnt++;
    end else begin
      bcnt = 0;
      io_ready = 1'b0;
    end
    if (done) begin done_cnt++; done_tick = tick; end
    if (io_read && first_rd < 0) first_rd = tick;
    if (io_read) rd_hi++;
    if (read_ready) rr_cnt++;
    if (read_ready && prev_rr) rr_multi++;
    if (io_read && io_write) both_hi++;
    if (busy) busy_seen = 1'b1;
    if (io_read || io_write) strobe_seen = 1'b1;
    if (io_byte_size !== (busy ? 2'b10 : 2'b00)) bsz_err++;
    if ((io_read && prev_rd && io_addr != prev_addr) ||
        (io_write && prev_wr && (io_addr != prev_addr || io_wdata != prev_wdata))) stab_err++;
    prev_rr = read_ready; prev_rd = io_read; prev_wr = io_write;
    prev_addr = io_addr; prev_wdata = io_wdata;
  end

  int t0, done_base, el;

  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(negedge pclk); #1;
    src_addr = s; dst_addr = d; word_count = n; start = 1'b1;
    t0 = tick; done_base = done_cnt;
    first_rd = -1; wr_n = 0; rd_idx = 0; rr_cnt = 0; rd_hi = 0;
    @(negedge pclk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int elapsed);
    while (done_cnt == done_base && tick - t0 < max_cyc) begin
      @(negedge pclk); #1;
    end
    elapsed = (done_cnt == done_base) ? -1 : done_tick - t0;
  endtask

  task automatic wait_tick(input int t);
    while (tick < t) begin
      @(negedge pclk); #1;
    end
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_strobes", {30'd0, io_read, io_write}, 0);
    chk("rst_read_ready", 32'(read_ready), 0);
    chk("rst_status", 32'(status), 0);
    chk("rst_addr", io_addr, 0);
    chk("rst_wdata", io_wdata, 0);
    chk("rst_bsize", 32'(io_byte_size), 0);
    @(negedge pclk); #1 rst_n = 1'b1;

    // Three-word copy, immediate io_ready
    rd_vals[0] = 32'h1111_1111; rd_vals[1] = 32'h2222_2222;
    rd_vals[2] = 32'h3333_3333; rd_vals[3] = 32'h4444_4444;
    dly = 0; stab_err = 0; rr_multi = 0;
    start_xfer(32'h0000_0100, 32'h8000_0000, 16'd3);
    wait_done(100, el);
    chk("c3_done_cycle", el, 16);
    chk("c3_first_read", first_rd - t0, 2);
    chk("c3_writes", wr_n, 3);
    chk("c3_wa0", wr_addr[0], 32'h8000_0000);
    chk("c3_wd0", wr_dat[0], 32'h1111_1111);
    chk("c3_wa1", wr_addr[1], 32'h8000_0004);
    chk("c3_wd1", wr_dat[1], 32'h2222_2222);
    chk("c3_wa2", wr_addr[2], 32'h8000_0008);
    chk("c3_wd2", wr_dat[2], 32'h3333_3333);
    chk("c3_status", 32'(status), 0);
    chk("c3_read_ready_cnt", rr_cnt, 3);
    chk("c3_burst", {28'd0, burst, burst_size}, 0);

    // Zero count
    @(negedge pclk); #1;
    busy_seen = 0; strobe_seen = 0;
    start_xfer(32'h0000_0200, 32'h8000_0100, 16'd0);
    wait_done(10, el);
    chk("c0_done_cycle", el, 1);
    @(negedge pclk); #1;
    chk("c0_busy_seen", 32'(busy_seen), 0);
    chk("c0_strobe_seen", 32'(strobe_seen), 0);

    // Seven-cycle io_ready delay, two words
    dly = 7; stab_err = 0; rr_multi = 0;
    rd_vals[0] = 32'hDEAD_BEEF; rd_vals[1] = 32'h0BAD_F00D;
    start_xfer(32'hFFFF_FFFC, 32'h1000_0000, 16'd2);
    wait_done(200, el);
    chk("d7_done_cycle", el, 39);
    chk("d7_stable", stab_err, 0);
    chk("d7_rr_single", rr_multi, 0);
    chk("d7_rr_cnt", rr_cnt, 2);
    chk("d7_writes", wr_n, 2);
    chk("d7_wd0", wr_dat[0], 32'hDEAD_BEEF);
    chk("d7_wd1", wr_dat[1], 32'h0BAD_F00D);
    chk("d7_wa1", wr_addr[1], 32'h1000_0004);

    // Abort during second RD_WAIT of a four-word copy
    dly = 3;
    start_xfer(32'h0000_0000, 32'h2000_0000, 16'd4);
    wait_tick(t0 + 14);
    chk("ab_read_before", 32'(io_read), 1);
    abort = 1'b1;
    @(negedge pclk); #1;
    abort = 1'b0;
    chk("ab_read_dropped", 32'(io_read), 0);
    chk("ab_done", 32'(done), 1);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_status", 32'(status), 2);
    chk("ab_writes", wr_n, 1);

    // No io_ready at all
    dly = 100000;
    start_xfer(32'h0000_0040, 32'h3000_0000, 16'd1);
`ifdef DMA_TIMEOUT_EN
    wait_done(100, el);
    chk("to_done_cycle", el, 10);
    chk("to_read_cycles", rd_hi, 8);
    chk("to_status", 32'(status), 1);
`else
    wait_tick(t0 + 40);
    chk("nt_read_held", 32'(io_read), 1);
    chk("nt_busy_held", 32'(busy), 1);
    abort = 1'b1;
    @(negedge pclk); #1;
    abort = 1'b0;
    chk("nt_abort_status", 32'(status), 2);
`endif
    chk("never_both_strobes", both_hi, 0);
    chk("byte_size_track", bsz_err, 0);

    // Asynchronous reset in WR_WAIT
    dly = 5;
    @(negedge pclk); #1;
    start_xfer(32'h0000_0010, 32'h4000_0000, 16'd1);
    wait_tick(t0 + 11);
    chk("rs_in_wr_wait", 32'(io_write), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_write", 32'(io_write), 0);
    chk("rs_busy", 32'(busy), 0);
    chk("rs_addr", io_addr, 0);
    chk("rs_wdata", io_wdata, 0);
    chk("rs_bsize", 32'(io_byte_size), 0);
    @(negedge pclk); #1;
    chk("rs_no_done", done_cnt - done_base, 0);
    rst_n = 1'b1;
    dly = 0;
    rd_vals[0] = 32'hCAFE_F00D;
    start_xfer(32'h0000_0020, 32'h5000_0000, 16'd1);
    wait_done(50, el);
    chk("rs_after_cycle", el, 6);
    chk("rs_after_wd", wr_dat[0], 32'hCAFE_F00D);
    chk("rs_after_wa", wr_addr[0], 32'h5000_0000);
    chk("rs_after_status", 32'(status), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
